// File: rtl/misr_resp_compactor_pkg.sv
// rtl/misr_resp_compactor_pkg.sv - shared types, default polynomials and width helper for the MISR compactor
// Purpose : package misr_pkg, imported by every file of the compactor.
// Contents: state_t   - FSM states IDLE / RUN / DONE
//           POLY_N4   - default feedback taps for N=4 (x^4 implicit)
//           POLY_N8   - default feedback taps for N=8 (x^8 implicit)
//           cnt_width - width of a counter able to hold 0..num_pat
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] POLY_N4 = 4'h3;
    localparam logic [7:0] POLY_N8 = 8'h1D;

    function automatic int cnt_width(input int num_pat);
        return $clog2(num_pat + 1);
    endfunction

endpackage

// File: rtl/misr_resp_compactor_if.sv
// rtl/misr_resp_compactor_if.sv - response-word handshake between CUT outputs and the compactor
// Purpose : bundles the response stream into one port.
// Signals : resp_valid - word present (upstream drives)
//           resp_ready - compactor accepts a word (compactor drives)
//           resp_data  - N-bit response word
//           resp_xmask - N-bit X mask, only when MISR_X_MASK_EN is defined
// Modports: master - upstream source; slave - the compactor.
// Macro   : MISR_X_MASK_EN adds resp_xmask.
interface misr_resp_compactor_if #(
    parameter int N = 8
);
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_data;
`ifdef MISR_X_MASK_EN
    logic [N-1:0] resp_xmask;

    modport master (output resp_valid, output resp_data, output resp_xmask, input resp_ready);
    modport slave  (input resp_valid, input resp_data, input resp_xmask, output resp_ready);
`else
    modport master (output resp_valid, output resp_data, input resp_ready);
    modport slave  (input resp_valid, input resp_data, output resp_ready);
`endif
endinterface

// File: rtl/misr_resp_compactor_misr_reg.sv
// rtl/misr_resp_compactor_misr_reg.sv - multiple-input signature register with seed load and shift enable
// Purpose : holds the signature; load has priority over shift.
// Ports   : clk, rst_n   - clock, async active-low reset (signature -> SEED)
//           i_load       - reload SEED
//           i_shift_en   - absorb i_data this edge
//           i_data       - word to fold in
//           o_sig        - current signature
//           o_sig_next   - signature after absorbing i_data
module misr_reg #(
    parameter int           N    = 8,
    parameter logic [N-1:0] POLY = 'h1D,
    parameter logic [N-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_shift_en,
    input  logic [N-1:0] i_data,
    output logic [N-1:0] o_sig,
    output logic [N-1:0] o_sig_next
);
    logic [N-1:0] r_sig;

    // Galois-style step: shift left, fold POLY back in when the MSB falls out.
    always_comb begin
        o_sig_next = {r_sig[N-2:0], 1'b0} ^ (r_sig[N-1] ? POLY : '0) ^ i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= SEED;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_shift_en) begin
            r_sig <= o_sig_next;
        end
    end

    assign o_sig = r_sig;
endmodule

// File: rtl/misr_resp_compactor.sv
// rtl/misr_resp_compactor.sv - MISR response compactor with pattern counter and golden compare
// Purpose : absorbs NUM_PAT response words, then reports signature == golden.
// Ports   : clk, rst_n  - clock, async active-low reset
//           start       - begin a run (honoured in IDLE/DONE only), latches golden
//           golden      - expected signature
//           rif         - response handshake (slave modport)
//           signature   - current MISR contents
//           pat_count   - words absorbed this run, saturating at NUM_PAT
//           busy / done - in RUN / in DONE
//           pass        - valid while done
// Macro   : MISR_X_MASK_EN - absorbed word is resp_data & ~resp_xmask.
module misr_resp_compactor
    import misr_pkg::*;
#(
    parameter int           N       = 8,
    parameter int           NUM_PAT = 16,
    parameter logic [N-1:0] POLY    = 'h1D,
    parameter logic [N-1:0] SEED    = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [N-1:0]                    golden,
    misr_resp_compactor_if.slave            rif,
    output logic [N-1:0]                    signature,
    output logic [cnt_width(NUM_PAT)-1:0]   pat_count,
    output logic                            busy,
    output logic                            done,
    output logic                            pass
);
    localparam int CW = cnt_width(NUM_PAT);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_golden;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    logic            w_fire;
    logic            w_start_acc;
    logic [N-1:0]    w_word;
    logic [N-1:0]    w_sig;
    logic [N-1:0]    w_sig_next;

`ifdef MISR_X_MASK_EN
    assign w_word = rif.resp_data & ~rif.resp_xmask;
`else
    assign w_word = rif.resp_data;
`endif

    // r_ready is high exactly in RUN, so the fire term needs no state decode.
    assign w_fire      = rif.resp_valid & r_ready;
    assign w_start_acc = start & (r_state != RUN);

    misr_reg #(
        .N    (N),
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_start_acc),
        .i_shift_en (w_fire),
        .i_data     (w_word),
        .o_sig      (w_sig),
        .o_sig_next (w_sig_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_golden <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= RUN;
                        r_cnt    <= '0;
                        r_golden <= golden;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        if (r_cnt != CW'(NUM_PAT)) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                        if (r_cnt == CW'(NUM_PAT - 1)) begin
                            // Compare against the value the MISR takes on this same edge.
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_sig_next == r_golden);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign rif.resp_ready = r_ready;
    assign signature      = w_sig;
    assign pat_count      = r_cnt;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
endmodule

// File: tb/tb_misr_resp_compactor.sv
// tb/tb_misr_resp_compactor.sv - directed self-checking bench for misr_resp_compactor
module tb_misr_resp_compactor;
    import misr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [3:0] golden_a = 4'h0;
    logic [3:0] golden_b = 4'h0;

    logic [3:0] sig_a, sig_b;
    logic [1:0] cnt_a;
    logic [2:0] cnt_b;
    logic       busy_a, done_a, pass_a;
    logic       busy_b, done_b, pass_b;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    misr_resp_compactor_if #(.N(4)) ifa ();
    misr_resp_compactor_if #(.N(4)) ifb ();

    misr_resp_compactor #(.N(4), .NUM_PAT(2), .POLY(POLY_N4), .SEED(4'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .golden(golden_a), .rif(ifa),
        .signature(sig_a), .pat_count(cnt_a), .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    misr_resp_compactor #(.N(4), .NUM_PAT(4), .POLY(POLY_N4), .SEED(4'h0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .golden(golden_b), .rif(ifb),
        .signature(sig_b), .pat_count(cnt_b), .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vecs++; if (sig_a !== 4'h0) begin errs++; $display("FAIL reset_sig got=%h exp=0", sig_a); end
        vecs++; if (cnt_a !== 2'd0) begin errs++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
        vecs++; if ({ifa.resp_ready, busy_a, done_a, pass_a} !== 4'b0000) begin
            errs++; $display("FAIL reset_flags got=%b exp=0000", {ifa.resp_ready, busy_a, done_a, pass_a}); end
    endtask

    task automatic test_pass_run;
        start_a = 1'b1; golden_a = 4'hB;
        tick;
        start_a = 1'b0; golden_a = 4'h0;
        vecs++; if ({ifa.resp_ready, busy_a, done_a} !== 3'b110) begin
            errs++; $display("FAIL run_entry got=%b exp=110", {ifa.resp_ready, busy_a, done_a}); end
        ifa.resp_valid = 1'b1; ifa.resp_data = 4'h8;
        tick;
        vecs++; if (sig_a !== 4'h8) begin errs++; $display("FAIL pass_w1_sig got=%h exp=8", sig_a); end
        vecs++; if (done_a !== 1'b0) begin errs++; $display("FAIL pass_w1_done got=%b exp=0", done_a); end
        tick;
        ifa.resp_valid = 1'b0;
        vecs++; if (sig_a !== 4'hB) begin errs++; $display("FAIL pass_w2_sig got=%h exp=b", sig_a); end
        vecs++; if ({done_a, pass_a, busy_a, ifa.resp_ready} !== 4'b1100) begin
            errs++; $display("FAIL pass_done_flags got=%b exp=1100", {done_a, pass_a, busy_a, ifa.resp_ready}); end
        vecs++; if (cnt_a !== 2'd2) begin errs++; $display("FAIL pass_cnt got=%0d exp=2", cnt_a); end
        // Word offered while in DONE must not be absorbed.
        ifa.resp_valid = 1'b1; ifa.resp_data = 4'hF;
        tick;
        ifa.resp_valid = 1'b0;
        vecs++; if ({sig_a, cnt_a, done_a, pass_a} !== {4'hB, 2'd2, 2'b11}) begin
            errs++; $display("FAIL done_hold got=%h/%0d/%b%b exp=b/2/11", sig_a, cnt_a, done_a, pass_a); end
    endtask

    task automatic test_fail_run;
        start_a = 1'b1; golden_a = 4'hA;
        tick;
        start_a = 1'b0;
        vecs++; if ({sig_a, done_a, pass_a, busy_a} !== {4'h0, 3'b001}) begin
            errs++; $display("FAIL restart got=%h/%b%b%b exp=0/001", sig_a, done_a, pass_a, busy_a); end
        ifa.resp_valid = 1'b1; ifa.resp_data = 4'h8;
        tick; tick;
        ifa.resp_valid = 1'b0;
        vecs++; if ({sig_a, done_a, pass_a} !== {4'hB, 2'b10}) begin
            errs++; $display("FAIL fail_run got=%h/%b%b exp=b/10", sig_a, done_a, pass_a); end
    endtask

    task automatic test_gaps;
        logic [3:0] words [4];
        logic [3:0] exps  [4];
        words = '{4'h1, 4'h2, 4'h4, 4'h8};
        exps  = '{4'h1, 4'h0, 4'h4, 4'h0};
        start_b = 1'b1; golden_b = 4'h0;
        tick;
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifb.resp_valid = 1'b1; ifb.resp_data = words[i];
            tick;
            ifb.resp_valid = 1'b0; ifb.resp_data = 4'hF;
            vecs++; if (sig_b !== exps[i]) begin errs++; $display("FAIL gap_sig%0d got=%h exp=%h", i, sig_b, exps[i]); end
            vecs++; if (done_b !== (i == 3)) begin errs++; $display("FAIL gap_done%0d got=%b exp=%b", i, done_b, (i == 3)); end
            tick;
            vecs++; if ({sig_b, cnt_b} !== {exps[i], 3'(i + 1)}) begin
                errs++; $display("FAIL gap_idle%0d got=%h/%0d exp=%h/%0d", i, sig_b, cnt_b, exps[i], i + 1); end
        end
        vecs++; if (pass_b !== 1'b1) begin errs++; $display("FAIL gap_pass got=%b exp=1", pass_b); end
    endtask

    task automatic test_start_in_run;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        ifb.resp_valid = 1'b1; ifb.resp_data = 4'h1;
        tick;
        start_b = 1'b1; ifb.resp_data = 4'h2;
        tick;
        start_b = 1'b0; ifb.resp_valid = 1'b0;
        vecs++; if ({sig_b, cnt_b, busy_b} !== {4'h0, 3'd2, 1'b1}) begin
            errs++; $display("FAIL start_in_run got=%h/%0d/%b exp=0/2/1", sig_b, cnt_b, busy_b); end
    endtask

    task automatic test_reset_mid_run;
        // dut_b is in RUN with 2 words absorbed; make the signature non-seed first.
        ifb.resp_valid = 1'b1; ifb.resp_data = 4'h5;
        tick;
        ifb.resp_valid = 1'b0;
        vecs++; if ({sig_b, cnt_b} !== {4'h5, 3'd3}) begin
            errs++; $display("FAIL pre_reset got=%h/%0d exp=5/3", sig_b, cnt_b); end
        rst_n = 1'b0;
        tick;
        vecs++; if ({sig_b, cnt_b, done_b, ifb.resp_ready, busy_b} !== {4'h0, 3'd0, 3'b000}) begin
            errs++; $display("FAIL reset_mid_run got=%h/%0d/%b%b%b exp=0/0/000", sig_b, cnt_b, done_b, ifb.resp_ready, busy_b); end
        rst_n = 1'b1;
        tick;
    endtask

`ifdef MISR_X_MASK_EN
    task automatic test_xmask;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        ifa.resp_valid = 1'b1; ifa.resp_data = 4'hF; ifa.resp_xmask = 4'hC;
        tick;
        ifa.resp_valid = 1'b0; ifa.resp_xmask = 4'h0;
        vecs++; if (sig_a !== 4'h3) begin errs++; $display("FAIL xmask got=%h exp=3", sig_a); end
    endtask
`endif

    initial begin
        ifa.resp_valid = 1'b0; ifa.resp_data = 4'h0;
        ifb.resp_valid = 1'b0; ifb.resp_data = 4'h0;
`ifdef MISR_X_MASK_EN
        ifa.resp_xmask = 4'h0; ifb.resp_xmask = 4'h0;
`endif
        tick; tick;
        test_reset;
        rst_n = 1'b1;
        tick;
        test_reset;
        test_pass_run;
        test_fail_run;
        test_gaps;
        test_start_in_run;
        test_reset_mid_run;
`ifdef MISR_X_MASK_EN
        test_xmask;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
